din_sequencer: RTL and testbench

DIN_SEQUENCER -- requirements
Module: din_sequencer

---
 rtl/laoc2_pkg.sv | 20 ++
 rtl/prog_mem.sv | 21 ++
 rtl/din_sequencer.sv | 121 ++++++++++++
 tb/tb_din_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/laoc2_pkg.sv
// Shared definitions for the DIN sequencer: FSM states, move-immediate opcode and opcode field.
package laoc2_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [3:0] MVI_OP_DEFAULT = 4'b0001;
  localparam int         OPC_MSB        = 15;
  localparam int         OPC_LSB        = 12;

  function automatic logic is_opcode(input logic [15:0] word, input logic [3:0] op);
    return word[OPC_MSB:OPC_LSB] == op;
  endfunction

endpackage

// File: rtl/prog_mem.sv
// 16x16 program buffer: synchronous write, asynchronous read, contents survive reset.
module prog_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [3:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem_q [16];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/din_sequencer.sv
// Feeds buffered program words to a processor over DIN/Run, one instruction in flight;
// issue is one cycle, then waits for Done (bounded by TIMEOUT) before the next word.
module din_sequencer
  import laoc2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [3:0]  MVI_OP  = MVI_OP_DEFAULT
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Load,
  input  logic [3:0]  LoadAddr,
  input  logic [15:0] LoadData,
  input  logic [4:0]  ProgLen,
  input  logic        Start,
  input  logic        Done,
  output logic [15:0] DIN,
  output logic        Run,
  output logic [4:0]  PC,
  output logic [15:0] ContaInstrucao,
  output logic        Busy,
  output logic        Finished,
  output logic        Error
);

  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t         state_q, state_d;
  logic [4:0]     pc_q, pc_d;
  logic [4:0]     len_q, len_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [15:0]    rd_word;

  assign Busy           = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign Finished       = (state_q == S_FINISH);
  assign Error          = (state_q == S_ERROR);
  assign PC             = pc_q;
  assign ContaInstrucao = cnt_q;

  prog_mem u_prog_mem (
    .clk   (Clock),
    .we    (Load && !Busy),
    .waddr (LoadAddr),
    .wdata (LoadData),
    .raddr (pc_q[3:0]),
    .rdata (rd_word)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    DIN     = '0;
    Run     = 1'b0;

    case (state_q)
      S_IDLE, S_FINISH, S_ERROR: begin
        if (Start) begin
          len_d   = (ProgLen > 5'd16) ? 5'd16 : ProgLen;
          pc_d    = '0;
          state_d = (ProgLen == 5'd0) ? S_FINISH : S_ISSUE;
        end
      end

      S_ISSUE: begin
        wait_d = '0;
        if (is_opcode(rd_word, MVI_OP)) begin
          // A move-immediate in the last slot has no immediate word to follow it.
          if (pc_q == len_q - 5'd1) begin
            state_d = S_ERROR;
          end else begin
            DIN     = rd_word;
            Run     = 1'b1;
            pc_d    = pc_q + 5'd1;
            state_d = S_WAIT;
          end
        end else begin
          DIN     = rd_word;
          Run     = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // pc_q already points at the immediate for mvi, so one read covers both cases.
        DIN = rd_word;
        if (Done) begin
          cnt_d   = cnt_q + 16'd1;
          pc_d    = pc_q + 5'd1;
          state_d = (pc_q + 5'd1 == len_q) ? S_FINISH : S_ISSUE;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_din_sequencer.sv
// Directed bench for din_sequencer with hand-computed expectations.
module tb_din_sequencer;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Load = 1'b0;
  logic [3:0]  LoadAddr = '0;
  logic [15:0] LoadData = '0;
  logic [4:0]  ProgLen = '0;
  logic        Start = 1'b0;
  logic        Done = 1'b0;
  logic [15:0] DIN;
  logic        Run;
  logic [4:0]  PC;
  logic [15:0] ContaInstrucao;
  logic        Busy, Finished, Error;

  int checks = 0;
  int errors = 0;
  int run_cnt = 0;
  int r0;

  din_sequencer #(.TIMEOUT(15), .MVI_OP(4'b0001)) dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .Load           (Load),
    .LoadAddr       (LoadAddr),
    .LoadData       (LoadData),
    .ProgLen        (ProgLen),
    .Start          (Start),
    .Done           (Done),
    .DIN            (DIN),
    .Run            (Run),
    .PC             (PC),
    .ContaInstrucao (ContaInstrucao),
    .Busy           (Busy),
    .Finished       (Finished),
    .Error          (Error)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (Run) run_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [15:0] d);
    Load = 1'b1; LoadAddr = a; LoadData = d;
    step();
    Load = 1'b0;
  endtask

  task automatic start(input logic [4:0] len);
    ProgLen = len; Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  // From ISSUE: enter WAIT, answer Done in the first WAIT cycle.
  task automatic finish_instr();
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_run", 32'(Run), 0);
    check("rst_din", 32'(DIN), 0);
    check("rst_pc", 32'(PC), 0);
    check("rst_cnt", 32'(ContaInstrucao), 0);
    check("rst_flags", 32'({Busy, Finished, Error}), 0);
    step(); step();
    Resetn = 1'b1;

    // Two plain instructions, Done three cycles after each Run
    load_word(4'd0, 16'h2040);
    load_word(4'd1, 16'h3080);
    r0 = run_cnt;
    start(5'd2);
    check("A_run0", 32'(Run), 1);
    check("A_din0", 32'(DIN), 'h2040);
    check("A_busy", 32'(Busy), 1);
    step();
    check("A_wait_run", 32'(Run), 0);
    check("A_wait_din", 32'(DIN), 'h2040);
    step(); step();
    Done = 1'b1; step(); Done = 1'b0;
    check("A_run1", 32'(Run), 1);
    check("A_din1", 32'(DIN), 'h3080);
    check("A_pc1", 32'(PC), 1);
    check("A_cnt1", 32'(ContaInstrucao), 1);
    repeat (3) step();
    Done = 1'b1; step(); Done = 1'b0;
    check("A_fin", 32'(Finished), 1);
    check("A_busy_fin", 32'(Busy), 0);
    check("A_cnt2", 32'(ContaInstrucao), 2);
    check("A_pc2", 32'(PC), 2);
    check("A_din_fin", 32'(DIN), 0);
    check("A_runs", 32'(run_cnt - r0), 2);
    Done = 1'b1; step(); Done = 1'b0;
    check("A_done_ignored", 32'(ContaInstrucao), 2);

    // Move-immediate: immediate word shown during WAIT
    load_word(4'd0, 16'h1000);
    load_word(4'd1, 16'h00AB);
    start(5'd2);
    check("B_run", 32'(Run), 1);
    check("B_din_op", 32'(DIN), 'h1000);
    check("B_pc0", 32'(PC), 0);
    step();
    check("B_din_imm", 32'(DIN), 'h00AB);
    check("B_pc1", 32'(PC), 1);
    check("B_wait_run", 32'(Run), 0);
    step();
    check("B_din_hold", 32'(DIN), 'h00AB);
    Done = 1'b1; step(); Done = 1'b0;
    check("B_fin", 32'(Finished), 1);
    check("B_pc2", 32'(PC), 2);
    check("B_cnt", 32'(ContaInstrucao), 3);

    // Move-immediate in last slot
    r0 = run_cnt;
    start(5'd1);
    check("C_issue_run", 32'(Run), 0);
    check("C_issue_busy", 32'(Busy), 1);
    step();
    check("C_err", 32'({Error, Finished, Busy}), 'b100);
    check("C_no_run", 32'(run_cnt - r0), 0);
    check("C_cnt", 32'(ContaInstrucao), 3);

    // Empty program goes straight to FINISH
    r0 = run_cnt;
    start(5'd0);
    check("Z_flags", 32'({Error, Finished, Busy}), 'b010);
    check("Z_no_run", 32'(run_cnt - r0), 0);

    // Timeout after 15 WAIT cycles
    load_word(4'd0, 16'h2040);
    start(5'd1);
    check("D_run", 32'(Run), 1);
    repeat (15) step();
    check("D_last_wait", 32'(Busy), 1);
    step();
    check("D_err", 32'(Error), 1);
    check("D_cnt", 32'(ContaInstrucao), 3);
    start(5'd1);
    check("D_reissue_run", 32'(Run), 1);
    check("D_reissue_din", 32'(DIN), 'h2040);
    check("D_reissue_pc", 32'(PC), 0);
    finish_instr();
    check("D_fin", 32'(Finished), 1);
    check("D_cnt2", 32'(ContaInstrucao), 4);

    // Asynchronous reset in WAIT
    load_word(4'd1, 16'h3080);
    start(5'd2);
    finish_instr();
    step();
    check("E_wait_din", 32'(DIN), 'h3080);
    check("E_wait_pc", 32'(PC), 1);
    check("E_cnt_pre", 32'(ContaInstrucao), 5);
    #2 Resetn = 1'b0;
    #1;
    check("E_rst_run", 32'(Run), 0);
    check("E_rst_din", 32'(DIN), 0);
    check("E_rst_pc", 32'(PC), 0);
    check("E_rst_cnt", 32'(ContaInstrucao), 0);
    check("E_rst_busy", 32'(Busy), 0);
    step();
    Resetn = 1'b1;
    start(5'd2);
    check("E_mem0", 32'(DIN), 'h2040);
    finish_instr();
    check("E_mem1", 32'(DIN), 'h3080);
    finish_instr();
    check("E_fin", 32'(Finished), 1);
    check("E_cnt", 32'(ContaInstrucao), 2);

    // Load and Start while Busy are dropped
    start(5'd2);
    Load = 1'b1; LoadAddr = 4'd0; LoadData = 16'hFFFF; Start = 1'b1;
    step();
    Load = 1'b0; Start = 1'b0;
    check("F_wait_busy", 32'(Busy), 1);
    check("F_wait_pc", 32'(PC), 0);
    check("F_wait_din", 32'(DIN), 'h2040);
    Load = 1'b1; LoadAddr = 4'd1; LoadData = 16'hDEAD;
    step();
    Load = 1'b0;
    Done = 1'b1; step(); Done = 1'b0;
    check("F_din1", 32'(DIN), 'h3080);
    finish_instr();
    check("F_cnt", 32'(ContaInstrucao), 4);
    start(5'd2);
    check("F_mem0", 32'(DIN), 'h2040);
    finish_instr();
    finish_instr();
    check("F_cnt2", 32'(ContaInstrucao), 6);

    // ProgLen above 16 runs all 16 words
    for (int i = 0; i < 16; i++) load_word(4'(i), 16'('h2000 + i));
    start(5'd31);
    for (int i = 0; i < 16; i++) begin
      check("G_din", 32'(DIN), 32'('h2000 + i));
      check("G_pc", 32'(PC), 32'(i));
      finish_instr();
    end
    check("G_fin", 32'(Finished), 1);
    check("G_pc16", 32'(PC), 16);
    check("G_cnt", 32'(ContaInstrucao), 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=done");
    $fatal(1);
  end

endmodule
